water_flow_supervisor: RTL and testbench
========================================

WATER_FLOW_SUPERVISOR -- requirements
Module: water_flow_supervisor

Interface
REQ-001 Parameter LEVEL_W, default 10: sensor width in bits.
REQ-002 Parameter THRESHOLD, default 10: minimum level change that counts as progress.
REQ-003 Parameter TIME_LIMIT, default 1000: consecutive non-progress samples tolerated before a timeout fault.
REQ-004 Parameter LEAK_THRESHOLD, default 5: maximum deviation allowed in HOLD.
REQ-005 clk  in  1  system clock; all logic on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 water_level_sensor  in  LEVEL_W  unsigned level sample.
REQ-008 sample_valid  in  1  sensor sample qualifier; logic evaluates only when high.
REQ-009 mode  in  2  00 IDLE, 01 FILL, 10 DRAIN, 11 HOLD.
REQ-010 err_clear  in  1  clears a latched fault.
REQ-011 error_flag  out  1  fault latched.
REQ-012 error_code  out  2  00 none, 01 timeout, 10 wrong direction, 11 leak.
REQ-013 progress  out  1  one-cycle pulse on a valid progress sample.
REQ-014 fault_count  out  8  faults since reset; present only with the stats feature (REQ-032).

Function
REQ-015 The FSM SHALL have three states: WAIT_BASE, MONITOR and FAULT; all outputs SHALL be registered, with 1-cycle latency from the qualifying sample.
REQ-016 WAIT_BASE: the first sample_valid SHALL load baseline <= sensor, clear the counter and go to MONITOR; mode IDLE SHALL hold the FSM in WAIT_BASE.
REQ-017 FILL progress: sensor > baseline + THRESHOLD, computed in LEVEL_W+1 bits (no wrap).
REQ-018 DRAIN progress: baseline >= THRESHOLD and sensor < baseline - THRESHOLD; if baseline < THRESHOLD, no DRAIN progress is possible.
REQ-019 On a progress sample, baseline SHALL be set to the sensor value, the counter cleared and progress pulsed.
REQ-020 Wrong direction: a FILL sample with sensor + THRESHOLD < baseline, or a DRAIN sample with sensor > baseline + THRESHOLD (both computed in LEVEL_W+1 bits), SHALL go to FAULT with code 10.
REQ-021 HOLD: |sensor - baseline| > LEAK_THRESHOLD SHALL go to FAULT with code 11; HOLD SHALL never time out.
REQ-022 FILL/DRAIN timeout: each valid non-progress sample SHALL increment the counter; the sample that brings it to TIME_LIMIT SHALL go to FAULT with code 01; the counter SHALL saturate and never wrap.
REQ-023 Priority within one sample SHALL be wrong-direction, then leak, then progress, then timeout.
REQ-024 A mode change (mode differs from the registered previous mode) SHALL force WAIT_BASE and clear the counter without raising a fault; in FAULT, the latched error SHALL persist.
REQ-025 FAULT: error_flag=1 and error_code held; the FSM SHALL ignore samples until err_clear.
REQ-026 err_clear SHALL clear error_flag and error_code and go to WAIT_BASE; err_clear in the same cycle as a new fault SHALL let the fault win.
REQ-027 err_clear outside FAULT SHALL be a no-op.
REQ-028 sample_valid low SHALL freeze the counter and baseline.

Reset
REQ-029 reset_n low SHALL asynchronously force WAIT_BASE, clear baseline, counter, previous mode and fault_count, and set error_flag=0, error_code=00 and progress=0.
REQ-030 Reset asserted mid-fault or mid-count SHALL discard all state; the first valid sample after release SHALL be the new baseline.
REQ-031 Reset release SHALL be synchronous to clk from the outside (no internal synchroniser).

Configuration
REQ-032 Macro WFS_FAULT_STATS_EN: when defined, fault_count SHALL increment (saturating at 255) on each entry to FAULT; when undefined, the fault_count port and its counter SHALL be absent.

Structure
REQ-033 Package wfs_pkg SHALL hold the mode, error-code and state enums and the counter-width function (clog2(TIME_LIMIT+1)).
REQ-034 The no-progress counter SHALL be sub-module wfs_timeout_counter (inputs: clear, inc; output: expired; saturating).

Verification (bench uses TIME_LIMIT=8, THRESHOLD=10, LEAK_THRESHOLD=5)
REQ-035 FILL, base 100, then 111, 122 -> two progress pulses, error_flag=0.
REQ-036 FILL, base 100, then 8 samples of 105 -> error_flag=1, code 01, the cycle after the 8th sample.
REQ-037 DRAIN, base 200, then sample 215 -> code 10 next cycle; err_clear -> error_flag=0, FSM in WAIT_BASE.
REQ-038 HOLD, base 300, samples 303 then 306 -> no fault at 303, code 11 after 306.
REQ-039 DRAIN, base 5, 8 samples of 0 -> timeout code 01, no underflow; FILL, base 1020, sample 1023 -> no progress, no wrap.
REQ-040 Reset_n pulsed mid-count (count 5) -> all outputs 0; mode switch FILL->DRAIN at count 7 -> no fault, counter restarts.

Source files
------------

// File: rtl/wfs_pkg.sv
// Shared types for the water flow supervisor: operating modes, fault codes,
// FSM states and the no-progress counter width helper.
package wfs_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_FILL  = 2'b01,
        MODE_DRAIN = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_TIMEOUT   = 2'b01,
        ERR_WRONG_DIR = 2'b10,
        ERR_LEAK      = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ST_WAIT_BASE = 2'b00,
        ST_MONITOR   = 2'b01,
        ST_FAULT     = 2'b10
    } state_e;

    // Bits needed to hold 0..limit inclusive; never less than one.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/water_flow_supervisor_if.sv
// Sensor/mode/fault bundle between the supervisor and its environment.
// fault_count exists only when WFS_FAULT_STATS_EN is defined.
interface water_flow_supervisor_if #(
    parameter int LEVEL_W = 10
);
    logic [LEVEL_W-1:0] water_level_sensor;
    logic               sample_valid;
    logic [1:0]         mode;
    logic               err_clear;
    logic               error_flag;
    logic [1:0]         error_code;
    logic               progress;
`ifdef WFS_FAULT_STATS_EN
    logic [7:0]         fault_count;
`endif

    modport slave (
`ifdef WFS_FAULT_STATS_EN
        output fault_count,
`endif
        input  water_level_sensor, sample_valid, mode, err_clear,
        output error_flag, error_code, progress
    );

    modport master (
`ifdef WFS_FAULT_STATS_EN
        input  fault_count,
`endif
        output water_level_sensor, sample_valid, mode, err_clear,
        input  error_flag, error_code, progress
    );
endinterface

// File: rtl/wfs_timeout_counter.sv
// Saturating no-progress counter; expired flags the increment that reaches
// TIME_LIMIT so the caller can fault on that very sample.
module wfs_timeout_counter
    import wfs_pkg::*;
#(
    parameter int TIME_LIMIT = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam int CNT_W = cnt_width(TIME_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIME_LIMIT);
    localparam logic [CNT_W-1:0] LAST_OK = CNT_W'(TIME_LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise count up and stick at the limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = inc && !clear && (count_q >= LAST_OK);
endmodule

// File: rtl/water_flow_supervisor.sv
// Tank fill/drain/hold supervisor: tracks a level baseline, pulses progress,
// and latches timeout / wrong-direction / leak faults until err_clear.
// Optional fault statistics counter: define WFS_FAULT_STATS_EN.
module water_flow_supervisor
    import wfs_pkg::*;
#(
    parameter int LEVEL_W        = 10,
    parameter int THRESHOLD      = 10,
    parameter int TIME_LIMIT     = 1000,
    parameter int LEAK_THRESHOLD = 5
) (
    input  logic clk,
    input  logic reset_n,
    water_flow_supervisor_if.slave bus
);
    localparam int EXT_W = LEVEL_W + 1;
    localparam logic [LEVEL_W:0]   THR_X  = EXT_W'(THRESHOLD);
    localparam logic [LEVEL_W-1:0] LEAK_L = LEVEL_W'(LEAK_THRESHOLD);

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] baseline_q, baseline_d;
    mode_e              prev_mode_q;
    logic               error_flag_q, error_flag_d;
    err_e               error_code_q, error_code_d;
    logic               progress_q, progress_d;

    mode_e              mode_s;
    logic [LEVEL_W:0]   sensor_x_s, base_x_s;
    logic [LEVEL_W-1:0] diff_s;
    logic               mode_chg_s, wrong_s, leak_s, prog_s, timed_s;
    logic               cnt_clear_s, cnt_inc_s, cnt_expired_s;

    assign mode_s     = mode_e'(bus.mode);
    assign mode_chg_s = (mode_s != prev_mode_q);
    assign sensor_x_s = {1'b0, bus.water_level_sensor};
    assign base_x_s   = {1'b0, baseline_q};
    assign diff_s     = (bus.water_level_sensor >= baseline_q) ?
                        (bus.water_level_sensor - baseline_q) :
                        (baseline_q - bus.water_level_sensor);

    // Per-mode classification of the current sample, widened so nothing wraps.
    always_comb begin
        wrong_s = 1'b0;
        leak_s  = 1'b0;
        prog_s  = 1'b0;
        timed_s = 1'b0;
        case (mode_s)
            MODE_FILL: begin
                wrong_s = (sensor_x_s + THR_X) < base_x_s;
                prog_s  = sensor_x_s > (base_x_s + THR_X);
                timed_s = 1'b1;
            end
            MODE_DRAIN: begin
                wrong_s = sensor_x_s > (base_x_s + THR_X);
                prog_s  = (base_x_s >= THR_X) && (sensor_x_s < (base_x_s - THR_X));
                timed_s = 1'b1;
            end
            MODE_HOLD: begin
                leak_s = diff_s > LEAK_L;
            end
            default: begin
                timed_s = 1'b0;
            end
        endcase
    end

    assign cnt_inc_s = (state_q == ST_MONITOR) && bus.sample_valid && !mode_chg_s &&
                       timed_s && !wrong_s && !prog_s;

    wfs_timeout_counter #(.TIME_LIMIT(TIME_LIMIT)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear_s),
        .inc     (cnt_inc_s),
        .expired (cnt_expired_s)
    );

    // Next-state and output decode; fault priority is wrong-dir, leak, progress, timeout.
    always_comb begin
        state_d      = state_q;
        baseline_d   = baseline_q;
        error_flag_d = error_flag_q;
        error_code_d = error_code_q;
        progress_d   = 1'b0;
        cnt_clear_s  = 1'b0;
        case (state_q)
            ST_WAIT_BASE: begin
                cnt_clear_s = 1'b1;
                if (bus.sample_valid && (mode_s != MODE_IDLE)) begin
                    baseline_d = bus.water_level_sensor;
                    state_d    = ST_MONITOR;
                end else begin
                    state_d = ST_WAIT_BASE;
                end
            end
            ST_MONITOR: begin
                if (mode_chg_s) begin
                    state_d     = ST_WAIT_BASE;
                    cnt_clear_s = 1'b1;
                end else if (!bus.sample_valid) begin
                    state_d = ST_MONITOR;
                end else if (wrong_s) begin
                    state_d      = ST_FAULT;
                    error_flag_d = 1'b1;
                    error_code_d = ERR_WRONG_DIR;
                end else if (leak_s) begin
                    state_d      = ST_FAULT;
                    error_flag_d = 1'b1;
                    error_code_d = ERR_LEAK;
                end else if (prog_s) begin
                    baseline_d  = bus.water_level_sensor;
                    cnt_clear_s = 1'b1;
                    progress_d  = 1'b1;
                end else if (cnt_expired_s) begin
                    state_d      = ST_FAULT;
                    error_flag_d = 1'b1;
                    error_code_d = ERR_TIMEOUT;
                end else begin
                    state_d = ST_MONITOR;
                end
            end
            ST_FAULT: begin
                if (bus.err_clear) begin
                    state_d      = ST_WAIT_BASE;
                    error_flag_d = 1'b0;
                    error_code_d = ERR_NONE;
                    cnt_clear_s  = 1'b1;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d     = ST_WAIT_BASE;
                cnt_clear_s = 1'b1;
            end
        endcase
    end

    // State, baseline and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_WAIT_BASE;
            baseline_q   <= '0;
            prev_mode_q  <= MODE_IDLE;
            error_flag_q <= 1'b0;
            error_code_q <= ERR_NONE;
            progress_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            baseline_q   <= baseline_d;
            prev_mode_q  <= mode_s;
            error_flag_q <= error_flag_d;
            error_code_q <= error_code_d;
            progress_q   <= progress_d;
        end
    end

    assign bus.error_flag = error_flag_q;
    assign bus.error_code = error_code_q;
    assign bus.progress   = progress_q;

`ifdef WFS_FAULT_STATS_EN
    logic [7:0] fault_count_q;

    // Count each entry into FAULT, sticking at 255.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_count_q <= 8'd0;
        end else if ((state_q != ST_FAULT) && (state_d == ST_FAULT) &&
                     (fault_count_q != 8'd255)) begin
            fault_count_q <= fault_count_q + 8'd1;
        end else begin
            fault_count_q <= fault_count_q;
        end
    end

    assign bus.fault_count = fault_count_q;
`endif
endmodule

// File: tb/tb_water_flow_supervisor.sv
// Vector-table bench for water_flow_supervisor (TIME_LIMIT=8, THRESHOLD=10,
// LEAK_THRESHOLD=5) with a scoreboard queue and hand-written reset sequences.
module tb_water_flow_supervisor;
    localparam int LW = 10;
    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_FILL  = 2'd1;
    localparam logic [1:0] M_DRAIN = 2'd2;
    localparam logic [1:0] M_HOLD  = 2'd3;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    water_flow_supervisor_if #(.LEVEL_W(LW)) bus ();

    water_flow_supervisor #(
        .LEVEL_W(LW), .THRESHOLD(10), .TIME_LIMIT(8), .LEAK_THRESHOLD(5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic          valid;
        logic [1:0]    mode;
        logic [LW-1:0] sensor;
        logic          clr;
        logic          flag;
        logic [1:0]    code;
        logic          prog;
    } vec_t;

    typedef struct {
        logic       flag;
        logic [1:0] code;
        logic       prog;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   vidx     = 0;

    function automatic void add(input logic v, input logic [1:0] m, input int s,
                                input logic c, input logic f, input logic [1:0] e,
                                input logic p);
        vec_t t;
        t.valid = v; t.mode = m; t.sensor = LW'(s); t.clr = c;
        t.flag = f;  t.code = e; t.prog = p;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic f, input logic [1:0] e, input logic p);
        checks++;
        if (bus.error_flag !== f || bus.error_code !== e || bus.progress !== p) begin
            failures++;
            $display("FAIL %s: got flag=%0b code=%0d prog=%0b, expected flag=%0b code=%0d prog=%0b",
                     name, bus.error_flag, bus.error_code, bus.progress, f, e, p);
        end
    endtask

    task automatic apply(input vec_t t);
        exp_t e;
        exp_t got;
        @(negedge clk);
        bus.sample_valid       = t.valid;
        bus.mode               = t.mode;
        bus.water_level_sensor = t.sensor;
        bus.err_clear          = t.clr;
        e.flag = t.flag; e.code = t.code; e.prog = t.prog; e.idx = vidx;
        sb.push_back(e);
        vidx++;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk($sformatf("vec%0d", got.idx), got.flag, got.code, got.prog);
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
        vecs.delete();
    endtask

    task automatic idle_inputs();
        bus.sample_valid = 1'b0;
        bus.err_clear    = 1'b0;
        bus.water_level_sensor = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.mode = M_IDLE;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("reset_state", 1'b0, 2'd0, 1'b0);
        reset_n = 1'b1;

        // Fill progress
        add(0, M_FILL, 0,   0, 0, 0, 0);
        add(1, M_FILL, 100, 0, 0, 0, 0);
        add(1, M_FILL, 111, 0, 0, 0, 1);
        add(1, M_FILL, 122, 0, 0, 0, 1);
        add(0, M_IDLE, 0,   0, 0, 0, 0);
        // Fill timeout on the 8th non-progress sample, then samples ignored in FAULT
        add(0, M_FILL, 0,   0, 0, 0, 0);
        add(1, M_FILL, 100, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(1, M_FILL, 105, 0, 0, 0, 0);
        add(1, M_FILL, 105, 0, 1, 1, 0);
        add(1, M_FILL, 150, 0, 1, 1, 0);
        add(0, M_FILL, 0,   1, 0, 0, 0);
        // Invalid samples freeze the counter
        add(1, M_FILL, 100, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, M_FILL, 105, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, M_FILL, 105, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, M_FILL, 105, 0, 0, 0, 0);
        add(1, M_FILL, 105, 0, 1, 1, 0);
        add(0, M_FILL, 0,   1, 0, 0, 0);
        // Drain wrong direction, clear, rebaseline; clear racing a new fault
        add(0, M_DRAIN, 0,   0, 0, 0, 0);
        add(1, M_DRAIN, 200, 0, 0, 0, 0);
        add(1, M_DRAIN, 215, 0, 1, 2, 0);
        add(0, M_DRAIN, 0,   1, 0, 0, 0);
        add(1, M_DRAIN, 50,  0, 0, 0, 0);
        add(1, M_DRAIN, 39,  0, 0, 0, 1);
        add(1, M_DRAIN, 60,  1, 1, 2, 0);
        add(0, M_DRAIN, 0,   1, 0, 0, 0);
        // Hold: no timeout, leak beyond 5
        add(0, M_HOLD, 0,   0, 0, 0, 0);
        add(1, M_HOLD, 300, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(1, M_HOLD, 300, 0, 0, 0, 0);
        add(1, M_HOLD, 303, 0, 0, 0, 0);
        add(1, M_HOLD, 306, 0, 1, 3, 0);
        add(0, M_HOLD, 0,   1, 0, 0, 0);
        // Drain from a base below THRESHOLD cannot progress and times out
        add(0, M_DRAIN, 0, 0, 0, 0, 0);
        add(1, M_DRAIN, 5, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(1, M_DRAIN, 0, 0, 0, 0, 0);
        add(1, M_DRAIN, 0, 0, 1, 1, 0);
        add(0, M_DRAIN, 0, 1, 0, 0, 0);
        // Fill near full scale: no wrap, then a large drop is wrong direction
        add(0, M_FILL, 0,    0, 0, 0, 0);
        add(1, M_FILL, 1020, 0, 0, 0, 0);
        add(1, M_FILL, 1023, 0, 0, 0, 0);
        add(1, M_FILL, 0,    0, 1, 2, 0);
        add(0, M_FILL, 0,    1, 0, 0, 0);
        // Build up a count of 5 before the mid-count reset
        add(1, M_FILL, 100, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(1, M_FILL, 105, 0, 0, 0, 0);
        run_vecs();

        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        #1;
        chk("reset_mid_count", 1'b0, 2'd0, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Count restarts after reset; FILL->DRAIN at count 7 is not a fault
        add(1, M_FILL, 100, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(1, M_FILL, 105, 0, 0, 0, 0);
        add(0, M_DRAIN, 0,   0, 0, 0, 0);
        add(1, M_DRAIN, 105, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(1, M_DRAIN, 105, 0, 0, 0, 0);
        add(1, M_DRAIN, 105, 0, 1, 1, 0);
        run_vecs();

        @(negedge clk);
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_fault", 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        add(1, M_DRAIN, 100, 0, 0, 0, 0);
        add(1, M_DRAIN, 89,  0, 0, 0, 1);
        run_vecs();

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
